// File: rtl/mure_block_builder_if.sv
// Event and block-entry bus for the E-trace block builder.
// slave is the builder's view; master is the producer/consumer around it.
interface mure_block_builder_if #(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned INST_LEN    = 32,
    parameter int unsigned IRETIRE_LEN = 8,
    parameter int unsigned ITYPE_LEN   = 3,
    parameter int unsigned CAUSE_LEN   = 5,
    parameter int unsigned PRIV_LEN    = 2
);
    logic                   valid_i;
    logic                   ready_o;
    logic [XLEN-1:0]        pc_i;
    logic [INST_LEN-1:0]    inst_data_i;
    logic                   compressed_i;
    logic                   exception_i;
    logic                   interrupt_i;
    logic                   eret_i;
    logic [CAUSE_LEN-1:0]   cause_i;
    logic [XLEN-1:0]        tval_i;
    logic [PRIV_LEN-1:0]    priv_i;

    logic                   valid_o;
    logic                   ready_i;
    logic [XLEN-1:0]        iaddr_o;
    logic [IRETIRE_LEN-1:0] iretire_o;
    logic                   ilastsize_o;
    logic [ITYPE_LEN-1:0]   itype_o;
    logic [CAUSE_LEN-1:0]   cause_o;
    logic [XLEN-1:0]        tval_o;
    logic [PRIV_LEN-1:0]    priv_o;

    modport slave (
        input  valid_i, pc_i, inst_data_i, compressed_i, exception_i, interrupt_i,
               eret_i, cause_i, tval_i, priv_i, ready_i,
        output ready_o, valid_o, iaddr_o, iretire_o, ilastsize_o, itype_o,
               cause_o, tval_o, priv_o
    );

    modport master (
        output valid_i, pc_i, inst_data_i, compressed_i, exception_i, interrupt_i,
               eret_i, cause_i, tval_i, priv_i, ready_i,
        input  ready_o, valid_o, iaddr_o, iretire_o, ilastsize_o, itype_o,
               cause_o, tval_o, priv_o
    );
endinterface

// File: rtl/mure_block_builder.sv
// Groups a serial retired-instruction stream into E-trace instruction blocks.
// Conditional-branch direction is resolved from the next accepted PC; finished
// blocks are queued in a small first-word-fall-through FIFO.
module mure_block_builder #(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned INST_LEN    = 32,
    parameter int unsigned IRETIRE_LEN = 8,
    parameter int unsigned ITYPE_LEN   = 3,
    parameter int unsigned CAUSE_LEN   = 5,
    parameter int unsigned PRIV_LEN    = 2,
    parameter int unsigned OUT_DEPTH   = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    mure_block_builder_if.slave bus
);
    localparam int unsigned PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [ITYPE_LEN-1:0] IT_NONE  = ITYPE_LEN'(0);
    localparam logic [ITYPE_LEN-1:0] IT_EXC   = ITYPE_LEN'(1);
    localparam logic [ITYPE_LEN-1:0] IT_INT   = ITYPE_LEN'(2);
    localparam logic [ITYPE_LEN-1:0] IT_ERET  = ITYPE_LEN'(3);
    localparam logic [ITYPE_LEN-1:0] IT_BR_NT = ITYPE_LEN'(4);
    localparam logic [ITYPE_LEN-1:0] IT_BR_TK = ITYPE_LEN'(5);
    localparam logic [ITYPE_LEN-1:0] IT_UNINF = ITYPE_LEN'(6);

    typedef struct packed {
        logic [XLEN-1:0]        iaddr;
        logic [IRETIRE_LEN-1:0] iretire;
        logic                   ilastsize;
        logic [ITYPE_LEN-1:0]   itype;
        logic [CAUSE_LEN-1:0]   cause;
        logic [XLEN-1:0]        tval;
    } entry_t;

    typedef enum logic [1:0] {ST_IDLE, ST_OPEN, ST_PEND} state_t;

    state_t                 state_q, state_d;
    logic [XLEN-1:0]        start_q, start_d;
    logic [IRETIRE_LEN-1:0] cnt_q, cnt_d;
    logic                   last_q, last_d;
    logic [XLEN-1:0]        br_pc_q, br_pc_d;
    logic [1:0]             br_hw_q, br_hw_d;
    logic [PRIV_LEN-1:0]    priv_q;

    entry_t                 mem_q [OUT_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       usage_q, usage_d;
    logic                   valid_q, ready_q;

    logic                   accept, pop, open_blk, ovf;
    logic [1:0]             size_hw;
    logic                   is_cbr, is_uninf;
    logic [IRETIRE_LEN:0]   sum_ext;
    logic [XLEN-1:0]        br_target;
    logic                   a_en, b_en;
    entry_t                 a_ent, b_ent;
    logic [1:0]             n_push;

    assign accept   = bus.valid_i && ready_q;
    assign pop      = valid_q && bus.ready_i;
    assign open_blk = (state_q == ST_OPEN);
    assign size_hw  = bus.compressed_i ? 2'd1 : 2'd2;

    // Instruction-class decode: conditional branches and uninferable jumps.
    assign is_cbr   = bus.compressed_i
                    ? (bus.inst_data_i[1:0] == 2'b01 && bus.inst_data_i[15:14] == 2'b11)
                    : (bus.inst_data_i[6:0] == 7'b1100011);
    assign is_uninf = bus.compressed_i
                    ? (bus.inst_data_i[1:0] == 2'b10 && bus.inst_data_i[15:13] == 3'b100 &&
                       bus.inst_data_i[11:7] != 5'd0 && bus.inst_data_i[6:2] == 5'd0)
                    : (bus.inst_data_i[6:0] == 7'b1100111);

    assign sum_ext   = (IRETIRE_LEN+1)'(cnt_q) + (IRETIRE_LEN+1)'(size_hw);
    assign ovf       = open_blk && sum_ext[IRETIRE_LEN];
    assign br_target = br_pc_q + (XLEN'(br_hw_q) << 1);

    // Block tracking: next state and up to two candidate FIFO entries per event.
    always_comb begin
        state_d = state_q;
        start_d = start_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        br_pc_d = br_pc_q;
        br_hw_d = br_hw_q;
        a_en    = 1'b0;
        a_ent   = '0;
        b_en    = 1'b0;
        b_ent   = '0;
        if (accept) begin
            if (state_q == ST_PEND) begin
                a_en            = 1'b1;
                a_ent.iaddr     = start_q;
                a_ent.iretire   = cnt_q;
                a_ent.ilastsize = last_q;
                a_ent.itype     = (bus.pc_i == br_target) ? IT_BR_NT : IT_BR_TK;
                state_d         = ST_IDLE;
            end
            if (bus.exception_i || bus.interrupt_i) begin
                b_en            = 1'b1;
                b_ent.iaddr     = open_blk ? start_q : bus.pc_i;
                b_ent.iretire   = open_blk ? cnt_q : '0;
                b_ent.ilastsize = open_blk ? last_q : 1'b0;
                b_ent.itype     = bus.exception_i ? IT_EXC : IT_INT;
                b_ent.cause     = bus.cause_i;
                b_ent.tval      = bus.tval_i;
                state_d         = ST_IDLE;
                cnt_d           = '0;
            end else begin
                if (ovf) begin
                    a_en            = 1'b1;
                    a_ent.iaddr     = start_q;
                    a_ent.iretire   = cnt_q;
                    a_ent.ilastsize = last_q;
                    a_ent.itype     = IT_NONE;
                end
                start_d = (open_blk && !ovf) ? start_q : bus.pc_i;
                cnt_d   = ((open_blk && !ovf) ? cnt_q : '0) + IRETIRE_LEN'(size_hw);
                last_d  = !bus.compressed_i;
                if (bus.eret_i || is_uninf) begin
                    b_en            = 1'b1;
                    b_ent.iaddr     = start_d;
                    b_ent.iretire   = cnt_d;
                    b_ent.ilastsize = last_d;
                    b_ent.itype     = bus.eret_i ? IT_ERET : IT_UNINF;
                    state_d         = ST_IDLE;
                end else if (is_cbr) begin
                    br_pc_d = bus.pc_i;
                    br_hw_d = size_hw;
                    state_d = ST_PEND;
                end else begin
                    state_d = ST_OPEN;
                end
            end
        end
    end

    // Block tracking registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            start_q <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            br_pc_q <= '0;
            br_hw_q <= '0;
            priv_q  <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            br_pc_q <= br_pc_d;
            br_hw_q <= br_hw_d;
            if (accept) priv_q <= bus.priv_i;
        end
    end

    assign n_push  = {1'b0, a_en} + {1'b0, b_en};
    assign usage_d = usage_q + CNT_W'(n_push) - CNT_W'(pop);

    // Output FIFO: branch/overflow entry written before the event's own entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usage_q  <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            if (a_en) begin
                mem_q[wr_ptr_q] <= a_ent;
                if (b_en) mem_q[wr_ptr_q + PTR_W'(1)] <= b_ent;
            end else if (b_en) begin
                mem_q[wr_ptr_q] <= b_ent;
            end
            wr_ptr_q <= wr_ptr_q + PTR_W'(n_push);
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
            usage_q  <= usage_d;
            valid_q  <= (usage_d != '0);
            ready_q  <= ((CNT_W'(OUT_DEPTH) - usage_d) >= CNT_W'(2));
        end
    end

    assign bus.ready_o     = ready_q;
    assign bus.valid_o     = valid_q;
    assign bus.iaddr_o     = mem_q[rd_ptr_q].iaddr;
    assign bus.iretire_o   = mem_q[rd_ptr_q].iretire;
    assign bus.ilastsize_o = mem_q[rd_ptr_q].ilastsize;
    assign bus.itype_o     = mem_q[rd_ptr_q].itype;
    assign bus.cause_o     = mem_q[rd_ptr_q].cause;
    assign bus.tval_o      = mem_q[rd_ptr_q].tval;
    assign bus.priv_o      = priv_q;
endmodule

// File: tb/tb_mure_block_builder.sv
// Self-checking bench for mure_block_builder: table of events with expected
// block entries, scoreboard queue, and hand-written overflow/backpressure/reset sequences.
module tb_mure_block_builder;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] JALR  = 32'h0000_80E7;
    localparam logic [31:0] BEQ   = 32'h0000_0063;
    localparam logic [31:0] JAL   = 32'h0000_006F;
    localparam logic [31:0] MRET  = 32'h3020_0073;
    localparam logic [31:0] CNOP  = 32'h0000_0001;
    localparam logic [31:0] CBEQZ = 32'h0000_C001;
    localparam logic [31:0] CJR   = 32'h0000_8082;
    localparam logic [31:0] CJALR = 32'h0000_9082;
    localparam logic [31:0] CJ    = 32'h0000_A001;
    localparam logic [31:0] CMV   = 32'h0000_8086;

    typedef struct packed {
        logic [63:0] iaddr;
        logic [7:0]  iretire;
        logic        ilast;
        logic [2:0]  itype;
        logic [4:0]  cause;
        logic [63:0] tval;
    } exp_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        c;
        logic [2:0]  flags;   // {exception, interrupt, eret}
        logic [4:0]  cause;
        logic [63:0] tval;
        logic [1:0]  n_exp;
        exp_t        e0;
        exp_t        e1;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];
    vec_t vecs[$];

    mure_block_builder_if bus ();

    mure_block_builder dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t ex(input logic [63:0] a, input int r, input logic l, input int t,
                                input int ca, input logic [63:0] tv);
        exp_t e;
        e.iaddr = a; e.iretire = 8'(r); e.ilast = l; e.itype = 3'(t);
        e.cause = 5'(ca); e.tval = tv;
        return e;
    endfunction

    function automatic vec_t mk(input logic [63:0] pc, input logic [31:0] inst, input logic c,
                                input logic [2:0] fl, input int ca, input logic [63:0] tv,
                                input int n, input exp_t e0, input exp_t e1);
        vec_t v;
        v.pc = pc; v.inst = inst; v.c = c; v.flags = fl; v.cause = 5'(ca); v.tval = tv;
        v.n_exp = 2'(n); v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    // Drive one event, push its expected entries, wait (bounded) for acceptance.
    task automatic send(input vec_t v);
        int cyc;
        @(negedge clk);
        bus.pc_i         = v.pc;
        bus.inst_data_i  = v.inst;
        bus.compressed_i = v.c;
        bus.exception_i  = v.flags[2];
        bus.interrupt_i  = v.flags[1];
        bus.eret_i       = v.flags[0];
        bus.cause_i      = v.cause;
        bus.tval_i       = v.tval;
        bus.valid_i      = 1'b1;
        if (v.n_exp > 0) sb.push_back(v.e0);
        if (v.n_exp > 1) sb.push_back(v.e1);
        cyc = 0;
        while (!bus.ready_o && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: ready_o stuck low for pc %h", v.pc);
        end
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while ((sb.size() != 0 || bus.valid_o) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 500) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: %0d entries still expected", sb.size());
        end
    endtask

    // Scoreboard: compare every entry popped by the downstream side.
    always @(negedge clk) begin
        if (!rst && bus.valid_o && bus.ready_i) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_entry: iaddr %h itype %0d", bus.iaddr_o, bus.itype_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("iaddr", bus.iaddr_o, e.iaddr);
                chk("iretire", 64'(bus.iretire_o), 64'(e.iretire));
                chk("ilastsize", 64'(bus.ilastsize_o), 64'(e.ilast));
                chk("itype", 64'(bus.itype_o), 64'(e.itype));
                chk("cause", 64'(bus.cause_o), 64'(e.cause));
                chk("tval", bus.tval_o, e.tval);
            end
        end
    end

    initial begin
        exp_t z;
        z = '0;
        bus.valid_i = 1'b0; bus.pc_i = '0; bus.inst_data_i = '0; bus.compressed_i = 1'b0;
        bus.exception_i = 1'b0; bus.interrupt_i = 1'b0; bus.eret_i = 1'b0;
        bus.cause_i = '0; bus.tval_i = '0; bus.priv_i = 2'd3; bus.ready_i = 1'b1;

        vecs.push_back(mk(64'h1000, NOP,  0, 3'b000, 0, 0, 0, z, z));
        vecs.push_back(mk(64'h1004, NOP,  0, 3'b000, 0, 0, 0, z, z));
        vecs.push_back(mk(64'h1008, JALR, 0, 3'b000, 0, 0, 1, ex(64'h1000, 6, 1, 6, 0, 0), z));
        vecs.push_back(mk(64'h2000, CBEQZ, 1, 3'b000, 0, 0, 0, z, z));
        vecs.push_back(mk(64'h2002, NOP,  0, 3'b000, 0, 0, 1, ex(64'h2000, 1, 0, 4, 0, 0), z));
        vecs.push_back(mk(64'h2006, JALR, 0, 3'b000, 0, 0, 1, ex(64'h2002, 4, 1, 6, 0, 0), z));
        vecs.push_back(mk(64'h2100, CBEQZ, 1, 3'b000, 0, 0, 0, z, z));
        vecs.push_back(mk(64'h3000, CJR,  1, 3'b000, 0, 0, 2, ex(64'h2100, 1, 0, 5, 0, 0),
                          ex(64'h3000, 1, 0, 6, 0, 0)));
        vecs.push_back(mk(64'h400, CNOP, 1, 3'b000, 0, 0, 0, z, z));
        vecs.push_back(mk(64'h402, CNOP, 1, 3'b000, 0, 0, 0, z, z));
        vecs.push_back(mk(64'h404, NOP,  0, 3'b100, 2, 64'hDEAD, 1,
                          ex(64'h400, 2, 0, 1, 2, 64'hDEAD), z));
        vecs.push_back(mk(64'h5000, BEQ, 0, 3'b000, 0, 0, 0, z, z));
        vecs.push_back(mk(64'h8000, NOP, 0, 3'b010, 7, 0, 2, ex(64'h5000, 2, 1, 5, 0, 0),
                          ex(64'h8000, 0, 0, 2, 7, 0)));
        vecs.push_back(mk(64'h6000, NOP,  0, 3'b000, 0, 0, 0, z, z));
        vecs.push_back(mk(64'h6004, MRET, 0, 3'b001, 0, 0, 1, ex(64'h6000, 4, 1, 3, 0, 0), z));
        vecs.push_back(mk(64'h7000, NOP,  0, 3'b100, 5, 64'h1234, 1,
                          ex(64'h7000, 0, 0, 1, 5, 64'h1234), z));
        vecs.push_back(mk(64'h7100, NOP,  0, 3'b111, 3, 64'h55, 1,
                          ex(64'h7100, 0, 0, 1, 3, 64'h55), z));
        vecs.push_back(mk(64'h7200, MRET, 0, 3'b011, 9, 64'h66, 1,
                          ex(64'h7200, 0, 0, 2, 9, 64'h66), z));
        vecs.push_back(mk(64'h9000, JAL,   0, 3'b000, 0, 0, 0, z, z));
        vecs.push_back(mk(64'h9004, CJ,    1, 3'b000, 0, 0, 0, z, z));
        vecs.push_back(mk(64'h9006, CMV,   1, 3'b000, 0, 0, 0, z, z));
        vecs.push_back(mk(64'h9008, CJALR, 1, 3'b000, 0, 0, 1, ex(64'h9000, 5, 0, 6, 0, 0), z));
        vecs.push_back(mk(64'hC000, CBEQZ, 1, 3'b000, 0, 0, 0, z, z));
        vecs.push_back(mk(64'hC002, BEQ,   0, 3'b000, 0, 0, 1, ex(64'hC000, 1, 0, 4, 0, 0), z));
        vecs.push_back(mk(64'hD000, JALR,  0, 3'b000, 0, 0, 2, ex(64'hC002, 2, 1, 5, 0, 0),
                          ex(64'hD000, 2, 1, 6, 0, 0)));
        vecs.push_back(mk(64'hFFFF_FFFF_FFFF_FFFC, BEQ, 0, 3'b000, 0, 0, 0, z, z));
        vecs.push_back(mk(64'h0, NOP, 0, 3'b000, 0, 0, 1,
                          ex(64'hFFFF_FFFF_FFFF_FFFC, 2, 1, 4, 0, 0), z));
        vecs.push_back(mk(64'h10, NOP, 0, 3'b100, 1, 64'h77, 1,
                          ex(64'h0, 2, 1, 1, 1, 64'h77), z));

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid_o", 64'(bus.valid_o), 64'd0);
        chk("rst_ready_o", 64'(bus.ready_o), 64'd1);
        chk("rst_iaddr_o", bus.iaddr_o, 64'd0);
        chk("rst_iretire_o", 64'(bus.iretire_o), 64'd0);
        chk("rst_ilastsize_o", 64'(bus.ilastsize_o), 64'd0);
        chk("rst_itype_o", 64'(bus.itype_o), 64'd0);
        chk("rst_cause_o", 64'(bus.cause_o), 64'd0);
        chk("rst_priv_o", 64'(bus.priv_o), 64'd0);

        foreach (vecs[i]) send(vecs[i]);
        chk("priv_o", 64'(bus.priv_o), 64'd3);
        wait_drain();

        // 130 sequential 32-bit instructions overflow the 8-bit half-word count.
        for (int i = 0; i < 130; i++) begin
            if (i == 127)
                send(mk(64'hA000 + 64'(4 * i), NOP, 0, 3'b000, 0, 0, 1,
                        ex(64'hA000, 254, 1, 0, 0, 0), z));
            else
                send(mk(64'hA000 + 64'(4 * i), NOP, 0, 3'b000, 0, 0, 0, z, z));
        end
        send(mk(64'hA208, JALR, 0, 3'b000, 0, 0, 1, ex(64'hA1FC, 8, 1, 6, 0, 0), z));
        wait_drain();

        // Backpressure: fill three entries, then offered events must be dropped.
        @(posedge clk);
        #1 bus.ready_i = 1'b0;
        send(mk(64'hB000, JALR, 0, 3'b000, 0, 0, 1, ex(64'hB000, 2, 1, 6, 0, 0), z));
        send(mk(64'hB010, JALR, 0, 3'b000, 0, 0, 1, ex(64'hB010, 2, 1, 6, 0, 0), z));
        send(mk(64'hB020, JALR, 0, 3'b000, 0, 0, 1, ex(64'hB020, 2, 1, 6, 0, 0), z));
        @(negedge clk);
        chk("bp_ready_o_low", 64'(bus.ready_o), 64'd0);
        chk("bp_valid_o", 64'(bus.valid_o), 64'd1);
        bus.pc_i = 64'hBAD0; bus.inst_data_i = JALR; bus.compressed_i = 1'b0;
        bus.valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_ready_o_hold", 64'(bus.ready_o), 64'd0);
            chk("bp_head_stable", bus.iaddr_o, 64'hB000);
        end
        bus.valid_i = 1'b0;
        @(posedge clk);
        #1 bus.ready_i = 1'b1;
        wait_drain();
        send(mk(64'hE000, JALR, 0, 3'b000, 0, 0, 1, ex(64'hE000, 2, 1, 6, 0, 0), z));
        wait_drain();

        // Reset mid-block discards the open block.
        send(mk(64'hF000, NOP, 0, 3'b000, 0, 0, 0, z, z));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid_o", 64'(bus.valid_o), 64'd0);
        send(mk(64'hF100, JALR, 0, 3'b000, 0, 0, 1, ex(64'hF100, 2, 1, 6, 0, 0), z));
        wait_drain();

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
